// File: rtl/lw_sha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lw_sha_pkg
// Description : Shared SHA/HMAC definitions: digest modes, chunk counts per
//               mode, and the big-endian 32-bit chunk selector used by the
//               digest serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package lw_sha_pkg;

  // Digest modes as presented by the engine
  typedef enum logic [2:0] {
    MODE_SHA256     = 3'd0,
    MODE_SHA224     = 3'd1,
    MODE_SHA512     = 3'd2,
    MODE_SHA384     = 3'd3,
    MODE_SHA512_256 = 3'd4,
    MODE_SHA512_224 = 3'd5
  } sha_mode_e;

  // Eight engine words, always held at 64 bits; 32-bit engines zero-extend
  typedef logic [7:0][63:0] digest_words_t;

  // Number of 32-bit output chunks per mode, indexed by sha_mode_e
  localparam logic [4:0] DIGEST_CHUNKS [6] = '{5'd8, 5'd7, 5'd16, 5'd12, 5'd8, 5'd7};

  // Index of the final chunk (N-1) for a mode
  function automatic logic [3:0] chunk_last_idx(input sha_mode_e mode);
    logic [4:0] n;
    n = 5'd8;
    case (mode)
      MODE_SHA256:     n = DIGEST_CHUNKS[0];
      MODE_SHA224:     n = DIGEST_CHUNKS[1];
      MODE_SHA512:     n = DIGEST_CHUNKS[2];
      MODE_SHA384:     n = DIGEST_CHUNKS[3];
      MODE_SHA512_256: n = DIGEST_CHUNKS[4];
      MODE_SHA512_224: n = DIGEST_CHUNKS[5];
      default:         n = 5'd8;
    endcase
    return 4'(n - 5'd1);
  endfunction

  // Chunk idx of the digest, big-endian (words[7] = H0 comes out first).
  // 32-bit modes use only the low half of each word; 64-bit modes emit
  // the upper half of a word before its lower half.
  function automatic logic [31:0] chunk_sel(input digest_words_t words,
                                            input sha_mode_e     mode,
                                            input logic [3:0]    idx);
    logic [63:0] w;
    logic [31:0] c;
    w = '0;
    c = '0;
    if (mode == MODE_SHA256 || mode == MODE_SHA224) begin
      w = words[3'd7 - idx[2:0]];
      c = w[31:0];
    end else begin
      w = words[3'd7 - idx[3:1]];
      c = idx[0] ? w[31:0] : w[63:32];
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lw_digest_serializer.sv
`default_nettype none
// ============================================================================
// Module      : lw_digest_serializer
// Description : Captures the SHA engine digest on each rising done and
//               streams it big-endian as 32-bit chunks over valid/ready,
//               truncated to the selected mode's digest length.
// Revision    : 1.0 - initial release
// ============================================================================
module lw_digest_serializer
  import lw_sha_pkg::*;
#(
  parameter int WORD_SIZE = 64
) (
  input  logic                      clk_i,
  input  logic                      aresetn_i,
  input  logic                      done_i,
  input  logic [7:0][WORD_SIZE-1:0] hash_i,
  input  logic [2:0]                mode_i,
  input  logic                      abort_i,
  input  logic                      out_ready_i,
  output logic                      out_valid_o,
  output logic [31:0]               out_data_o,
  output logic                      out_last_o,
  output logic                      busy_o,
  output logic                      overrun_o,
  output logic                      mode_err_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  state_e        r_state;
  logic          r_done_q;
  digest_words_t r_words;
  sha_mode_e     r_mode;
  logic [3:0]    r_idx;
  logic [3:0]    r_last_idx;
  logic          r_overrun;
  logic          r_mode_err;

  digest_words_t w_hash_ext;
  logic [2:0]    w_mode_eff;
  logic          w_mode_ok;
  logic          w_capture;
  logic          w_xfer;
  logic          w_final;

  // Normalise engine words to 64 bits and mask mode bits a 32-bit engine lacks
  generate
    if (WORD_SIZE == 64) begin : g_ws64
      assign w_hash_ext = hash_i;
      assign w_mode_eff = mode_i;
    end else begin : g_ws32
      for (genvar g = 0; g < 8; g++) begin : g_word
        assign w_hash_ext[g] = {32'h0, hash_i[g][31:0]};
      end
      assign w_mode_eff = {2'b00, mode_i[0]};
    end
  endgenerate

  assign w_mode_ok = (w_mode_eff <= 3'd5);
  assign w_capture = done_i & ~r_done_q;
  assign w_xfer    = (r_state == ST_STREAM) & out_ready_i;
  assign w_final   = w_xfer & (r_idx == r_last_idx);

  // Capture, stream and flag state machine
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state    <= ST_IDLE;
      r_done_q   <= 1'b0;
      r_words    <= '0;
      r_mode     <= MODE_SHA256;
      r_idx      <= 4'd0;
      r_last_idx <= 4'd0;
      r_overrun  <= 1'b0;
      r_mode_err <= 1'b0;
    end else begin
      r_done_q   <= done_i;
      r_overrun  <= 1'b0;
      r_mode_err <= 1'b0;
      if (abort_i) begin
        // Abort wins over any capture in the same cycle and raises no pulse
        r_state <= ST_IDLE;
        r_idx   <= 4'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_capture) begin
              if (w_mode_ok) begin
                r_words    <= w_hash_ext;
                r_mode     <= sha_mode_e'(w_mode_eff);
                r_last_idx <= chunk_last_idx(sha_mode_e'(w_mode_eff));
                r_idx      <= 4'd0;
                r_state    <= ST_STREAM;
              end else begin
                r_mode_err <= 1'b1;
              end
            end
          end
          ST_STREAM: begin
            if (w_final) begin
              // Back-to-back: a digest arriving on the final transfer chains on
              if (w_capture && w_mode_ok) begin
                r_words    <= w_hash_ext;
                r_mode     <= sha_mode_e'(w_mode_eff);
                r_last_idx <= chunk_last_idx(sha_mode_e'(w_mode_eff));
                r_idx      <= 4'd0;
              end else begin
                r_mode_err <= w_capture;
                r_idx      <= 4'd0;
                r_state    <= ST_IDLE;
              end
            end else begin
              if (w_xfer) begin
                r_idx <= r_idx + 4'd1;
              end
              // A digest arriving mid-stream is dropped and reported
              r_overrun <= w_capture;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
          end
        endcase
      end
    end
  end

  assign out_valid_o = (r_state == ST_STREAM);
  assign busy_o      = (r_state == ST_STREAM);
  assign out_data_o  = out_valid_o ? chunk_sel(r_words, r_mode, r_idx) : 32'h0;
  assign out_last_o  = out_valid_o & (r_idx == r_last_idx);
  assign overrun_o   = r_overrun;
  assign mode_err_o  = r_mode_err;

endmodule
`default_nettype wire

// File: tb/tb_lw_digest_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lw_digest_serializer
// Description : Directed self-checking bench for lw_digest_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lw_digest_serializer;

  logic             clk_i;
  logic             aresetn_i;
  logic             done_i;
  logic [7:0][63:0] hash_i;
  logic [2:0]       mode_i;
  logic             abort_i;
  logic             out_ready_i;
  logic             out_valid_o;
  logic [31:0]      out_data_o;
  logic             out_last_o;
  logic             busy_o;
  logic             overrun_o;
  logic             mode_err_o;

  logic [7:0][63:0] exp_hash;
  int               n_cmp = 0;
  int               n_err = 0;

  lw_digest_serializer #(.WORD_SIZE(64)) dut (
    .clk_i       (clk_i),
    .aresetn_i   (aresetn_i),
    .done_i      (done_i),
    .hash_i      (hash_i),
    .mode_i      (mode_i),
    .abort_i     (abort_i),
    .out_ready_i (out_ready_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o),
    .mode_err_o  (mode_err_o)
  );

  // Free-running clock, period 10
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: flatten the digest H0-first and cut it into 32-bit chunks
  function automatic logic [31:0] ref_chunk(input logic [2:0] m, input int k);
    logic [511:0] flat64;
    logic [255:0] flat32;
    for (int j = 0; j < 8; j++) begin
      flat64[64*j +: 64] = exp_hash[j];
      flat32[32*j +: 32] = exp_hash[j][31:0];
    end
    if (m <= 3'd1) return flat32[255-32*k -: 32];
    else           return flat64[511-32*k -: 32];
  endfunction

  function automatic logic [31:0] flags();
    return {27'd0, out_valid_o, out_last_o, busy_o, overrun_o, mode_err_o};
  endfunction

  // Consume chunks start..stop-1 of a total-chunk digest, optionally with backpressure
  task automatic drain(input logic [2:0] m, input int start, input int stop,
                       input int total, input bit bp);
    int          cnt;
    int          cyc;
    bit          stalled;
    logic [31:0] hold_d;
    cnt     = start;
    cyc     = 0;
    stalled = 0;
    hold_d  = '0;
    while (cnt < stop && cyc < 400) begin
      out_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid_o) begin
        chk("chunk_data", out_data_o, ref_chunk(m, cnt));
        chk("chunk_last", 32'(out_last_o), 32'(cnt == total - 1));
        if (stalled) chk("stall_stable", out_data_o, hold_d);
        if (out_ready_i) begin
          cnt++;
          stalled = 0;
        end else begin
          stalled = 1;
          hold_d  = out_data_o;
        end
      end
      tick();
      cyc++;
    end
    chk("chunk_count", 32'(cnt), 32'(stop));
    out_ready_i = 1'b1;
  endtask

  initial begin
    clk_i = 0; aresetn_i = 0; done_i = 0; hash_i = '0; mode_i = 3'd0;
    abort_i = 0; out_ready_i = 0; exp_hash = '0;

    // Reset state
    tick(); tick();
    chk("rst_flags", flags(), 32'd0);
    chk("rst_data", out_data_o, 32'd0);
    aresetn_i = 1;
    tick();
    chk("idle_flags", flags(), 32'd0);

    // Mode 0: words k, upper halves must be ignored
    for (int j = 0; j < 8; j++) hash_i[j] = {32'hBAD0_0000, 32'(j)};
    exp_hash = hash_i; mode_i = 3'd0; out_ready_i = 1; done_i = 1;
    tick();
    chk("m0_chunk0", out_data_o, 32'h0000_0007);
    chk("m0_valid_busy", {30'd0, out_valid_o, busy_o}, 32'd3);
    drain(3'd0, 0, 8, 8, 0);
    chk("m0_idle", {30'd0, out_valid_o, busy_o}, 32'd0);

    // Mode 3: 12 chunks, H6/H7 never emitted
    done_i = 0; tick();
    for (int j = 0; j < 8; j++) hash_i[j] = {16'hC0DE, 8'(j), 8'h00, 16'hF00D, 8'(j), 8'h11};
    hash_i[7] = 64'h0123_4567_89AB_CDEF;
    exp_hash = hash_i; mode_i = 3'd3; done_i = 1;
    tick();
    chk("m3_chunk0", out_data_o, 32'h0123_4567);
    tick();
    chk("m3_chunk1", out_data_o, 32'h89AB_CDEF);
    drain(3'd3, 1, 12, 12, 0);
    chk("m3_idle", 32'(out_valid_o), 32'd0);

    // Mode 5: chunk 6 is the upper half of H3
    done_i = 0; tick();
    for (int j = 0; j < 8; j++) hash_i[j] = {32'(j) * 32'h0101_0101, 32'h5555_0000 | 32'(j)};
    hash_i[4] = 64'hDEAD_BEEF_CAFE_F00D;
    exp_hash = hash_i; mode_i = 3'd5; done_i = 1;
    tick();
    repeat (6) tick();
    chk("m5_chunk6", out_data_o, 32'hDEAD_BEEF);
    chk("m5_last", 32'(out_last_o), 32'd1);
    tick();
    chk("m5_idle", 32'(out_valid_o), 32'd0);

    // Backpressure, mode 2
    done_i = 0; tick();
    for (int j = 0; j < 8; j++) hash_i[j] = {$urandom, $urandom};
    exp_hash = hash_i; mode_i = 3'd2; out_ready_i = 0; done_i = 1;
    tick();
    drain(3'd2, 0, 16, 16, 1);
    chk("bp_idle", 32'(out_valid_o), 32'd0);

    // Overrun mid-stream, then back-to-back capture on the final transfer
    done_i = 0; tick();
    for (int j = 0; j < 8; j++) hash_i[j] = {$urandom, $urandom};
    exp_hash = hash_i; mode_i = 3'd2; done_i = 1;
    tick();
    done_i = 0;
    drain(3'd2, 0, 3, 16, 0);
    for (int j = 0; j < 8; j++) hash_i[j] = {$urandom, $urandom};
    done_i = 1;
    tick();
    chk("ovr_pulse", 32'(overrun_o), 32'd1);
    chk("ovr_keep_data", out_data_o, ref_chunk(3'd2, 4));
    done_i = 0;
    tick();
    chk("ovr_single", 32'(overrun_o), 32'd0);
    drain(3'd2, 5, 15, 16, 0);
    chk("b2b_last", 32'(out_last_o), 32'd1);
    for (int j = 0; j < 8; j++) hash_i[j] = {$urandom, $urandom};
    mode_i = 3'd1; done_i = 1;
    tick();
    exp_hash = hash_i;
    chk("b2b_no_ovr", 32'(overrun_o), 32'd0);
    chk("b2b_no_gap", 32'(out_valid_o), 32'd1);
    drain(3'd1, 0, 7, 7, 0);
    chk("b2b_idle", 32'(out_valid_o), 32'd0);

    // Abort at chunk 4
    done_i = 0; tick();
    for (int j = 0; j < 8; j++) hash_i[j] = {$urandom, $urandom};
    exp_hash = hash_i; mode_i = 3'd0; done_i = 1;
    tick();
    drain(3'd0, 0, 4, 8, 0);
    abort_i = 1;
    tick();
    abort_i = 0;
    chk("abort_flags", flags(), 32'd0);
    tick();
    chk("abort_stays_idle", 32'(out_valid_o), 32'd0);

    // Invalid mode
    done_i = 0; tick();
    mode_i = 3'd7; done_i = 1;
    tick();
    chk("merr_pulse", flags(), 32'd1);
    tick();
    chk("merr_clear", flags(), 32'd0);

    // Asynchronous reset mid-stream
    done_i = 0; tick();
    mode_i = 3'd2; done_i = 1;
    tick(); tick();
    chk("rst_pre_valid", 32'(out_valid_o), 32'd1);
    #2 aresetn_i = 0;
    #1;
    chk("arst_flags", flags(), 32'd0);
    chk("arst_data", out_data_o, 32'd0);
    done_i = 0;
    tick(); tick();
    aresetn_i = 1;
    tick(); tick();
    chk("arst_no_resume", flags(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
